instruction_fetch: RTL and testbench

Fetch stage of the 24-bit processor: owns the program counter, requests instruction words from instruction memory over a req/ready handshake, and holds the fetched word stable for the field decoder and control unit until the downstream stage accepts it. It sits directly upstream of instruction field extraction. It also accepts PC redirects for branches and jumps, and discards any in-flight fetch the redirect invalidates.

---
 rtl/isa_pkg.sv | 28 ++
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isa_pkg.sv
// Shared definitions for the 24-bit processor: instruction layout and fetch FSM states.
package isa_pkg;

    localparam int unsigned INSTR_WIDTH = 24;

    // Instruction field widths, most significant field first.
    localparam int unsigned OP_WIDTH  = 6;   // bits 23..18
    localparam int unsigned REG_WIDTH = 2;   // Rs1 17..16, Rs2 15..14, Rd 13..12
    localparam int unsigned IMM_WIDTH = 12;  // bits 11..0

    // Packed view of an instruction word; member order fixes the bit positions.
    typedef struct packed {
        logic [OP_WIDTH-1:0]  op;
        logic [REG_WIDTH-1:0] rs1;
        logic [REG_WIDTH-1:0] rs2;
        logic [REG_WIDTH-1:0] rd;
        logic [IMM_WIDTH-1:0] imm;
    } instr_fields_t;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs the imem req/ready handshake, holds the fetched
// word until downstream accepts it, and handles branch/jump redirects.
module instruction_fetch
    import isa_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ready,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   instr_valid,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
    instr_fields_t         instr_q, instr_d;
    logic [ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
    logic                  instr_valid_q, instr_valid_d;
    logic [ADDR_WIDTH-1:0] pc_inc;

    // Sequential address after the one being fetched; wraps silently.
    always_comb begin
        pc_inc = req_addr_q + ADDR_WIDTH'(1);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode; a redirect outranks both stall and returning data.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    state_d = imem_ready ? FETCH : DRAIN;
                end else if (imem_ready) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid || !stall) begin
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (imem_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from registered state only; no input reaches imem_req/imem_addr.
    always_comb begin
        imem_req    = (state_q == FETCH) || (state_q == DRAIN);
        imem_addr   = req_addr_q;
        instr_valid = instr_valid_q;
        instr       = instr_q;
        instr_pc    = instr_pc_q;
    end

    // Datapath next values: PC, request address and the presented instruction.
    always_comb begin
        pc_d          = pc_q;
        req_addr_d    = req_addr_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    pc_d       = redirect_pc;
                    req_addr_d = redirect_pc;
                end else begin
                    req_addr_d = pc_q;
                end
            end
            FETCH: begin
                if (redirect_valid) begin
                    // Address only moves once the current handshake has completed.
                    pc_d = redirect_pc;
                    if (imem_ready) begin
                        req_addr_d = redirect_pc;
                    end
                end else if (imem_ready) begin
                    instr_d       = instr_fields_t'(imem_rdata);
                    instr_pc_d    = req_addr_q;
                    instr_valid_d = 1'b1;
                    pc_d          = pc_inc;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    instr_valid_d = 1'b0;
                    pc_d          = redirect_pc;
                    req_addr_d    = redirect_pc;
                end else if (!stall) begin
                    instr_valid_d = 1'b0;
                    req_addr_d    = pc_q;
                end
            end
            DRAIN: begin
                // Stale response is dropped; the most recent redirect target wins.
                if (redirect_valid) begin
                    pc_d = redirect_pc;
                    if (imem_ready) begin
                        req_addr_d = redirect_pc;
                    end
                end else if (imem_ready) begin
                    req_addr_d = pc_q;
                end
            end
            default: begin
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            req_addr_q    <= RESET_PC;
            instr_q       <= '0;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            req_addr_q    <= req_addr_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch with a variable-latency memory model.
module tb_instruction_fetch;

    localparam int unsigned AW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_ready = 1'b0;
    logic [23:0]   imem_rdata = 24'hBADBAD;
    logic          instr_valid;
    logic [23:0]   instr;
    logic [AW-1:0] instr_pc;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory model controls: wait cycles before ready, and one overridable word.
    int            mem_lat = 0;
    int            wcnt    = 0;
    logic          ov_en   = 1'b0;
    logic [AW-1:0] ov_addr = '0;
    logic [23:0]   ov_data = '0;

    // Scoreboards: expected fetch addresses and expected {instr_pc, instr} deliveries.
    logic [AW-1:0]    exp_addr_q[$];
    logic [AW+23:0]   exp_instr_q[$];

    instruction_fetch #(
        .ADDR_WIDTH(AW),
        .RESET_PC  (8'h00)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_rdata    (imem_rdata),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] mem_word(input logic [AW-1:0] a);
        if (ov_en && a == ov_addr) return ov_data;
        return 24'(a);
    endfunction

    // Memory responder: ready on the (mem_lat+1)-th cycle of each request.
    always @(negedge clk) begin
        if (!imem_req) begin
            wcnt       = 0;
            imem_ready = 1'b0;
            imem_rdata = 24'hBADBAD;
        end else begin
            if (imem_ready) wcnt = 0;
            imem_ready = (wcnt >= mem_lat);
            imem_rdata = imem_ready ? mem_word(imem_addr) : 24'hBADBAD;
            wcnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        ov_en          = 1'b0;
        exp_addr_q.delete();
        exp_instr_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; mem_lat = 0;
        tick();
        tick();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 8'h00) $display("FAIL reset_addr: got %h want 00", imem_addr); else n_pass++;
        n_checks++; if (instr_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", instr_valid); else n_pass++;
        n_checks++; if (instr !== 24'h0) $display("FAIL reset_instr: got %h want 000000", instr); else n_pass++;
        n_checks++; if (instr_pc !== 8'h00) $display("FAIL reset_instr_pc: got %h want 00", instr_pc); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1) $display("FAIL first_req: got %b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 8'h00) $display("FAIL first_addr: got %h want 00", imem_addr); else n_pass++;
    endtask

    task automatic test_stream();
        logic          prev_req, prev_valid;
        logic [AW-1:0] ea;
        logic [AW+23:0] ei;
        int            cyc, last_dv;
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_addr_q.push_back(AW'(i));
            exp_instr_q.push_back({AW'(i), 24'(i)});
        end
        prev_req = 1'b0; prev_valid = 1'b0; cyc = 0; last_dv = -1;
        while ((exp_addr_q.size() > 0 || exp_instr_q.size() > 0) && cyc < 40) begin
            tick();
            cyc++;
            if (imem_req && !prev_req && exp_addr_q.size() > 0) begin
                ea = exp_addr_q.pop_front();
                n_checks++; if (imem_addr !== ea) $display("FAIL stream_addr: got %h want %h", imem_addr, ea); else n_pass++;
            end
            if (instr_valid && !prev_valid && exp_instr_q.size() > 0) begin
                ei = exp_instr_q.pop_front();
                n_checks++; if ({instr_pc, instr} !== ei) $display("FAIL stream_instr: got pc %h instr %h want %h", instr_pc, instr, ei); else n_pass++;
                if (last_dv >= 0) begin
                    n_checks++; if (cyc - last_dv != 2) $display("FAIL stream_rate: got %0d cycles want 2", cyc - last_dv); else n_pass++;
                end
                last_dv = cyc;
            end
            prev_req = imem_req; prev_valid = instr_valid;
        end
        n_checks++; if (exp_addr_q.size() + exp_instr_q.size() != 0) $display("FAIL stream_timeout: %0d items left want 0", exp_addr_q.size() + exp_instr_q.size()); else n_pass++;
    endtask

    task automatic test_wait_state();
        logic [AW+23:0] ei;
        mem_lat = 2;
        do_reset();
        ov_en = 1'b1; ov_addr = 8'h00; ov_data = 24'hABCDEF;
        exp_instr_q.push_back({8'h00, 24'hABCDEF});
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0)
                $display("FAIL wait_hold_addr: cycle %0d got req %b addr %h valid %b want 1 00 0", c, imem_req, imem_addr, instr_valid);
            else n_pass++;
        end
        tick();
        n_checks++; if (imem_ready !== 1'b1 || instr_valid !== 1'b1) $display("FAIL wait_latency: got ready %b valid %b want 1 1", imem_ready, instr_valid); else n_pass++;
        ei = exp_instr_q.pop_front();
        n_checks++; if ({instr_pc, instr} !== ei) $display("FAIL wait_instr: got pc %h instr %h want %h", instr_pc, instr, ei); else n_pass++;
    endtask

    task automatic test_stall();
        logic [AW+23:0] ei;
        mem_lat = 0;
        do_reset();
        ov_en = 1'b1; ov_addr = 8'h00; ov_data = 24'h0C1234;
        exp_instr_q.push_back({8'h00, 24'h0C1234});
        stall = 1'b1;
        tick();
        tick();
        ei = exp_instr_q.pop_front();
        n_checks++; if (instr_valid !== 1'b1 || {instr_pc, instr} !== ei) $display("FAIL stall_present: got valid %b pc %h instr %h want 1 %h", instr_valid, instr_pc, instr, ei); else n_pass++;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++;
            if (instr_valid !== 1'b1 || instr !== 24'h0C1234 || instr_pc !== 8'h00 || imem_req !== 1'b0)
                $display("FAIL stall_hold: cycle %0d got valid %b instr %h pc %h req %b want 1 0c1234 00 0", c, instr_valid, instr, instr_pc, imem_req);
            else n_pass++;
        end
        stall = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h01 || instr_valid !== 1'b0) $display("FAIL stall_release: got req %b addr %h valid %b want 1 01 0", imem_req, imem_addr, instr_valid); else n_pass++;
    endtask

    task automatic test_redirect_fetch();
        logic           prev_valid;
        logic [AW+23:0] ei;
        int             cyc;
        mem_lat = 2;
        do_reset();
        exp_instr_q.push_back({8'h40, 24'h000040});
        tick();
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        tick();
        redirect_valid = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 8'h00 || instr_valid !== 1'b0)
                $display("FAIL redir_fetch_hold: cycle %0d got req %b addr %h valid %b want 1 00 0", c, imem_req, imem_addr, instr_valid);
            else n_pass++;
            tick();
        end
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40 || instr_valid !== 1'b0) $display("FAIL redir_fetch_new: got req %b addr %h valid %b want 1 40 0", imem_req, imem_addr, instr_valid); else n_pass++;
        prev_valid = 1'b0; cyc = 0;
        while (exp_instr_q.size() > 0 && cyc < 12) begin
            tick();
            cyc++;
            if (instr_valid && !prev_valid) begin
                ei = exp_instr_q.pop_front();
                n_checks++; if ({instr_pc, instr} !== ei) $display("FAIL redir_fetch_instr: got pc %h instr %h want %h", instr_pc, instr, ei); else n_pass++;
            end
            prev_valid = instr_valid;
        end
        n_checks++; if (exp_instr_q.size() != 0) $display("FAIL redir_fetch_timeout: %0d left want 0", exp_instr_q.size()); else n_pass++;
    endtask

    task automatic test_redirect_hold();
        logic           prev_valid;
        logic [AW+23:0] ei;
        int             cyc;
        mem_lat = 0;
        do_reset();
        stall = 1'b1;
        exp_instr_q.push_back({8'h10, 24'h000010});
        tick();
        tick();
        n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00) $display("FAIL redir_hold_pre: got valid %b pc %h want 1 00", instr_valid, instr_pc); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h10) $display("FAIL redir_hold: got valid %b req %b addr %h want 0 1 10", instr_valid, imem_req, imem_addr); else n_pass++;
        stall = 1'b0;
        prev_valid = 1'b0; cyc = 0;
        while (exp_instr_q.size() > 0 && cyc < 8) begin
            tick();
            cyc++;
            if (instr_valid && !prev_valid) begin
                ei = exp_instr_q.pop_front();
                n_checks++; if ({instr_pc, instr} !== ei) $display("FAIL redir_hold_instr: got pc %h instr %h want %h", instr_pc, instr, ei); else n_pass++;
            end
            prev_valid = instr_valid;
        end
        n_checks++; if (exp_instr_q.size() != 0) $display("FAIL redir_hold_timeout: %0d left want 0", exp_instr_q.size()); else n_pass++;
    endtask

    task automatic test_wrap();
        logic           prev_req, prev_valid;
        logic [AW-1:0]  ea;
        logic [AW+23:0] ei;
        int             cyc;
        mem_lat = 0;
        do_reset();
        exp_addr_q.push_back(8'hFF);
        exp_addr_q.push_back(8'h00);
        exp_addr_q.push_back(8'h01);
        exp_instr_q.push_back({8'hFF, 24'h0000FF});
        exp_instr_q.push_back({8'h00, 24'h000000});
        redirect_valid = 1'b1; redirect_pc = 8'hFF;
        tick();
        redirect_valid = 1'b0;
        ea = exp_addr_q.pop_front();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== ea) $display("FAIL wrap_idle_redirect: got req %b addr %h want 1 %h", imem_req, imem_addr, ea); else n_pass++;
        prev_req = 1'b1; prev_valid = 1'b0; cyc = 0;
        while ((exp_addr_q.size() > 0 || exp_instr_q.size() > 0) && cyc < 20) begin
            tick();
            cyc++;
            if (imem_req && !prev_req && exp_addr_q.size() > 0) begin
                ea = exp_addr_q.pop_front();
                n_checks++; if (imem_addr !== ea) $display("FAIL wrap_addr: got %h want %h", imem_addr, ea); else n_pass++;
            end
            if (instr_valid && !prev_valid && exp_instr_q.size() > 0) begin
                ei = exp_instr_q.pop_front();
                n_checks++; if ({instr_pc, instr} !== ei) $display("FAIL wrap_instr: got pc %h instr %h want %h", instr_pc, instr, ei); else n_pass++;
            end
            prev_req = imem_req; prev_valid = instr_valid;
        end
        n_checks++; if (exp_addr_q.size() + exp_instr_q.size() != 0) $display("FAIL wrap_timeout: %0d left want 0", exp_addr_q.size() + exp_instr_q.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_fetch();
        mem_lat = 2;
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 8'h30;
        tick();
        redirect_valid = 1'b0;
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h30) $display("FAIL rstmid_pre: got req %b addr %h want 1 30", imem_req, imem_addr); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if (imem_req !== 1'b0 || imem_addr !== 8'h00 || instr_valid !== 1'b0) $display("FAIL rstmid_abandon: got req %b addr %h valid %b want 0 00 0", imem_req, imem_addr, instr_valid); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h00) $display("FAIL rstmid_refetch: got req %b addr %h want 1 00", imem_req, imem_addr); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_wait_state();
        test_stall();
        test_redirect_fetch();
        test_redirect_hold();
        test_wrap();
        test_reset_mid_fetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
